// File: rtl/control_register_bank.sv
//==============================================================================
// Module      : control_register_bank
// Description : Shadow/active control register bank with masked edge-triggered
//               writes, atomic commit to the active bank and registered readback.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module control_register_bank #(
    parameter int NUM_REGS   = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0,
    parameter int AUTO_COMMIT = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH-1:0]          wr_mask,
    output logic                           wr_err,
    input  logic                           commit,
    output logic                           pending,
    output logic                           applied,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] active
);

    localparam int                c_bank_w      = NUM_REGS * DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_num_regs  = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic              c_auto_commit = (AUTO_COMMIT != 0);

    logic                  r_wr_en_q;
    logic [c_bank_w-1:0]   r_shadow;
    logic [c_bank_w-1:0]   w_shadow_next;
    logic [DATA_WIDTH-1:0] w_rd_val;
    logic                  w_edge;
    logic                  w_in_range;
    logic                  w_do_write;
    logic                  w_do_commit;

    assign w_edge      = wr_en & ~r_wr_en_q;
    assign w_in_range  = ({1'b0, wr_addr} < c_num_regs);
    assign w_do_write  = w_edge & w_in_range;
    assign w_do_commit = commit | (c_auto_commit & w_do_write);

    // Merged shadow is what a same-cycle commit forwards; readback sees the old shadow.
    always_comb begin
        w_shadow_next = r_shadow;
        w_rd_val      = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_do_write && (wr_addr == ADDR_WIDTH'(i))) begin
                w_shadow_next[i*DATA_WIDTH +: DATA_WIDTH] =
                    (r_shadow[i*DATA_WIDTH +: DATA_WIDTH] & ~wr_mask) | (wr_data & wr_mask);
            end
            if (rd_addr == ADDR_WIDTH'(i)) begin
                w_rd_val = r_shadow[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Edge detector resets high so a strobe held through reset is not a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en_q <= 1'b1;
            r_shadow  <= RESET_VALUES;
            active    <= RESET_VALUES;
            pending   <= 1'b0;
            applied   <= 1'b0;
            wr_err    <= 1'b0;
            rd_data   <= '0;
        end else begin
            r_wr_en_q <= wr_en;
            r_shadow  <= w_shadow_next;
            rd_data   <= w_rd_val;
            wr_err    <= w_edge & ~w_in_range;
            if (w_do_commit && (pending || w_do_write)) begin
                active  <= w_shadow_next;
                pending <= 1'b0;
                applied <= 1'b1;
            end else begin
                applied <= 1'b0;
                if (w_do_write) begin
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_register_bank.sv
//==============================================================================
// Module      : tb_control_register_bank
// Description : Self-checking bench for control_register_bank (three configs).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_control_register_bank;

    localparam logic [63:0] RV_A = 64'h00000000_A5000000;
    localparam logic [39:0] RV_B = 40'h34_00_00_00_12;
    localparam logic [63:0] RV_C = 64'h0;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic       commit;
    logic [2:0] wr_addr;
    logic [2:0] rd_addr;
    logic [7:0] wr_data;
    logic [7:0] wr_mask;

    logic        o_err  [3];
    logic        o_pend [3];
    logic        o_appl [3];
    logic [7:0]  o_rd   [3];
    logic [63:0] o_act  [3];
    logic [63:0] act_a;
    logic [39:0] act_b;
    logic [63:0] act_c;

    assign o_act[0] = act_a;
    assign o_act[1] = {24'h0, act_b};
    assign o_act[2] = act_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    control_register_bank #(.NUM_REGS(8), .DATA_WIDTH(8), .ADDR_WIDTH(3),
                            .RESET_VALUES(RV_A), .AUTO_COMMIT(0)) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_err(o_err[0]), .commit(commit), .pending(o_pend[0]),
        .applied(o_appl[0]), .rd_addr(rd_addr), .rd_data(o_rd[0]), .active(act_a));

    control_register_bank #(.NUM_REGS(5), .DATA_WIDTH(8), .ADDR_WIDTH(3),
                            .RESET_VALUES(RV_B), .AUTO_COMMIT(0)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_err(o_err[1]), .commit(commit), .pending(o_pend[1]),
        .applied(o_appl[1]), .rd_addr(rd_addr), .rd_data(o_rd[1]), .active(act_b));

    control_register_bank #(.NUM_REGS(8), .DATA_WIDTH(8), .ADDR_WIDTH(3),
                            .RESET_VALUES(RV_C), .AUTO_COMMIT(1)) dut_c (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_err(o_err[2]), .commit(commit), .pending(o_pend[2]),
        .applied(o_appl[2]), .rd_addr(rd_addr), .rd_data(o_rd[2]), .active(act_c));

    // Reference model: register contents as plain arrays, updated by the rules of operation.
    int         nregs   [3] = '{8, 5, 8};
    bit         autoc   [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] m_sh    [3][8];
    logic [7:0] m_act   [3][8];
    logic [7:0] m_rd    [3];
    bit         m_pend  [3];
    bit         m_appl  [3];
    bit         m_err   [3];
    bit         m_prev_en;
    bit         m_edge, m_inr, m_wrote, m_commit;

    function automatic logic [7:0] reset_val(int k, int i);
        if (k == 0 && i == 3) return 8'hA5;
        if (k == 1 && i == 0) return 8'h12;
        if (k == 1 && i == 4) return 8'h34;
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_prev_en = 1'b1;
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 8; i++) begin
                    m_sh[k][i]  = reset_val(k, i);
                    m_act[k][i] = reset_val(k, i);
                end
                m_rd[k] = 8'h00; m_pend[k] = 1'b0; m_appl[k] = 1'b0; m_err[k] = 1'b0;
            end
        end else begin
            m_edge    = wr_en && !m_prev_en;
            m_prev_en = wr_en;
            for (int k = 0; k < 3; k++) begin
                m_rd[k]  = (int'(rd_addr) < nregs[k]) ? m_sh[k][rd_addr] : 8'h00;
                m_inr    = int'(wr_addr) < nregs[k];
                m_wrote  = m_edge && m_inr;
                m_err[k] = m_edge && !m_inr;
                if (m_wrote)
                    m_sh[k][wr_addr] = (m_sh[k][wr_addr] & ~wr_mask) | (wr_data & wr_mask);
                m_commit = commit || (autoc[k] && m_wrote);
                if (m_commit && (m_pend[k] || m_wrote)) begin
                    for (int i = 0; i < 8; i++) m_act[k][i] = m_sh[k][i];
                    m_pend[k] = 1'b0;
                    m_appl[k] = 1'b1;
                end else begin
                    m_appl[k] = 1'b0;
                    if (m_wrote) m_pend[k] = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b1; commit = 1'b0;
        wr_addr = 3'd0; wr_data = 8'hEE; wr_mask = 8'hFF; rd_addr = 3'd3;
        step(); step();
        reset = 1'b0;
        step(); step();
        n_checks++;
        if (o_rd[0] !== 8'hA5) begin
            n_errors++; $display("FAIL reset_rd_a: got %h expected a5", o_rd[0]);
        end
        n_checks++;
        if (o_pend[0] !== 1'b0 || o_pend[1] !== 1'b0 || o_pend[2] !== 1'b0) begin
            n_errors++; $display("FAIL reset_pending: got %b%b%b expected 000", o_pend[0], o_pend[1], o_pend[2]);
        end
        n_checks++;
        if (act_a !== RV_A) begin
            n_errors++; $display("FAIL reset_active_a: got %h expected %h", act_a, RV_A);
        end
        n_checks++;
        if (act_b !== RV_B) begin
            n_errors++; $display("FAIL reset_active_b: got %h expected %h", act_b, RV_B);
        end
        n_checks++;
        if (act_c !== RV_C) begin
            n_errors++; $display("FAIL reset_active_c: got %h expected %h", act_c, RV_C);
        end
        wr_en = 1'b0;
        step();
    endtask

    task automatic test_masked_write();
        wr_addr = 3'd2; wr_data = 8'hFF; wr_mask = 8'h0F; wr_en = 1'b1; step();
        wr_en = 1'b0; step();
        wr_data = 8'h00; wr_mask = 8'hF0; wr_en = 1'b1; step();
        wr_en = 1'b0; rd_addr = 3'd2; step();
        n_checks++;
        if (o_rd[0] !== 8'h0F) begin
            n_errors++; $display("FAIL masked_rd: got %h expected 0f", o_rd[0]);
        end
        n_checks++;
        if (o_pend[0] !== 1'b1) begin
            n_errors++; $display("FAIL masked_pending: got %b expected 1", o_pend[0]);
        end
        n_checks++;
        if (act_a[23:16] !== 8'h00) begin
            n_errors++; $display("FAIL masked_active_before: got %h expected 00", act_a[23:16]);
        end
        commit = 1'b1; step();
        commit = 1'b0;
        n_checks++;
        if (act_a[23:16] !== 8'h0F || o_appl[0] !== 1'b1 || o_pend[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL masked_commit: got act=%h applied=%b pending=%b expected 0f 1 0",
                     act_a[23:16], o_appl[0], o_pend[0]);
        end
        step();
        n_checks++;
        if (o_appl[0] !== 1'b0) begin
            n_errors++; $display("FAIL masked_applied_pulse: got %b expected 0", o_appl[0]);
        end
    endtask

    task automatic test_held_strobe();
        wr_addr = 3'd1; wr_data = 8'h11; wr_mask = 8'hFF; wr_en = 1'b1; step();
        wr_data = 8'h22;
        repeat (4) step();
        wr_en = 1'b0; rd_addr = 3'd1; step();
        n_checks++;
        if (o_rd[0] !== 8'h11) begin
            n_errors++; $display("FAIL held_once: got %h expected 11", o_rd[0]);
        end
        wr_en = 1'b1; step();
        wr_en = 1'b0; step();
        n_checks++;
        if (o_rd[0] !== 8'h22) begin
            n_errors++; $display("FAIL held_rearm: got %h expected 22", o_rd[0]);
        end
        commit = 1'b1; step();
        commit = 1'b0; step();
    endtask

    task automatic test_simultaneous();
        n_checks++;
        if (o_pend[0] !== 1'b0) begin
            n_errors++; $display("FAIL simul_precond: got %b expected 0", o_pend[0]);
        end
        wr_addr = 3'd4; wr_data = 8'h5A; wr_mask = 8'hFF; wr_en = 1'b1; commit = 1'b1; step();
        n_checks++;
        if (act_a[39:32] !== 8'h5A || o_pend[0] !== 1'b0 || o_appl[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL simul_commit: got act=%h pending=%b applied=%b expected 5a 0 1",
                     act_a[39:32], o_pend[0], o_appl[0]);
        end
        wr_en = 1'b0; step();
        n_checks++;
        if (o_appl[0] !== 1'b0) begin
            n_errors++; $display("FAIL simul_second_commit: got %b expected 0", o_appl[0]);
        end
        commit = 1'b0; step();
    endtask

    task automatic test_out_of_range();
        wr_addr = 3'd6; wr_data = 8'hC3; wr_mask = 8'hFF; wr_en = 1'b1; step();
        n_checks++;
        if (o_err[1] !== 1'b1 || o_err[0] !== 1'b0) begin
            n_errors++; $display("FAIL oor_err: got b=%b a=%b expected 1 0", o_err[1], o_err[0]);
        end
        n_checks++;
        if (o_pend[1] !== 1'b0) begin
            n_errors++; $display("FAIL oor_pending: got %b expected 0", o_pend[1]);
        end
        wr_en = 1'b0; rd_addr = 3'd7; step();
        n_checks++;
        if (o_err[1] !== 1'b0) begin
            n_errors++; $display("FAIL oor_err_pulse: got %b expected 0", o_err[1]);
        end
        n_checks++;
        if (o_rd[1] !== 8'h00) begin
            n_errors++; $display("FAIL oor_read: got %h expected 00", o_rd[1]);
        end
        rd_addr = 3'd6; step();
        n_checks++;
        if (o_rd[0] !== 8'hC3 || o_rd[1] !== 8'h00) begin
            n_errors++; $display("FAIL oor_shadow: got a=%h b=%h expected c3 00", o_rd[0], o_rd[1]);
        end
        commit = 1'b1; step();
        commit = 1'b0; step();
    endtask

    task automatic test_auto_commit();
        wr_addr = 3'd0; wr_data = 8'h3C; wr_mask = 8'hFF; wr_en = 1'b1; step();
        n_checks++;
        if (act_c[7:0] !== 8'h3C || o_appl[2] !== 1'b1 || o_pend[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL auto_commit: got act=%h applied=%b pending=%b expected 3c 1 0",
                     act_c[7:0], o_appl[2], o_pend[2]);
        end
        wr_en = 1'b0; step();
        n_checks++;
        if (o_appl[2] !== 1'b0) begin
            n_errors++; $display("FAIL auto_applied_pulse: got %b expected 0", o_appl[2]);
        end
        wr_addr = 3'd5; wr_data = 8'h77; wr_en = 1'b1; step();
        reset = 1'b1; wr_en = 1'b0; step();
        reset = 1'b0; step();
        n_checks++;
        if (act_c !== RV_C || act_a !== RV_A || act_b !== RV_B) begin
            n_errors++;
            $display("FAIL reset_midop: got c=%h a=%h b=%h expected %h %h %h",
                     act_c, act_a, act_b, RV_C, RV_A, RV_B);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset   = ($urandom_range(0, 99) == 0);
            wr_en   = $urandom_range(0, 1) == 1;
            commit  = ($urandom_range(0, 4) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            rd_addr = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom);
            wr_mask = 8'($urandom);
            step();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (o_pend[k] !== m_pend[k] || o_appl[k] !== m_appl[k] || o_err[k] !== m_err[k]) begin
                    n_errors++;
                    $display("FAIL rand_flags dut%0d cyc%0d: got p=%b a=%b e=%b expected %b %b %b",
                             k, n, o_pend[k], o_appl[k], o_err[k], m_pend[k], m_appl[k], m_err[k]);
                end
                n_checks++;
                if (o_rd[k] !== m_rd[k]) begin
                    n_errors++;
                    $display("FAIL rand_rd dut%0d cyc%0d: got %h expected %h", k, n, o_rd[k], m_rd[k]);
                end
                for (int i = 0; i < nregs[k]; i++) begin
                    n_checks++;
                    if (o_act[k][i*8 +: 8] !== m_act[k][i]) begin
                        n_errors++;
                        $display("FAIL rand_active dut%0d reg%0d cyc%0d: got %h expected %h",
                                 k, i, n, o_act[k][i*8 +: 8], m_act[k][i]);
                    end
                end
            end
        end
        reset = 1'b0; wr_en = 1'b0; commit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_held_strobe();
        test_simultaneous();
        test_out_of_range();
        test_auto_commit();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_register_bank.md
# control_register_bank

Parametrised bank of NUM_REGS control registers, each DATA_WIDTH bits wide, replacing the single fixed 8-bit control register. Writes land in a shadow bank via an edge-detected write strobe with bit mask. The shadow is transferred atomically to the active bank on a commit request, so acquisition settings change together at a safe point. Software reads back shadow values through a registered read port. Sits between the host command decoder and the trigger/acquisition datapath.

## Interface
Parameters:
- NUM_REGS, 8, number of control registers (1..256)
- DATA_WIDTH, 8, bits per register (1..32)
- ADDR_WIDTH, $clog2(NUM_REGS) (min 1), address width
- RESET_VALUES, all zeros, flat NUM_REGS*DATA_WIDTH vector; register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- AUTO_COMMIT, 0, 1 = every accepted write also commits immediately

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- wr_en  input  1  write strobe; rising edge accepts one write
- wr_addr  input  ADDR_WIDTH  target register
- wr_data  input  DATA_WIDTH  write value
- wr_mask  input  DATA_WIDTH  1 = update that bit, 0 = keep shadow bit
- wr_err  output  1  one-cycle pulse: write edge with wr_addr >= NUM_REGS
- commit  input  1  level; copy shadow to active when sampled high
- pending  output  1  shadow differs from active by an uncommitted write
- applied  output  1  one-cycle pulse when active bank changed by commit
- rd_addr  input  ADDR_WIDTH  readback address
- rd_data  output  DATA_WIDTH  registered shadow value at rd_addr
- active  output  NUM_REGS*DATA_WIDTH  active bank, flat, same packing as RESET_VALUES

## Operation
- Write acceptance: edge = wr_en & ~wr_en_q, where wr_en_q is wr_en delayed one cycle. Exactly one write per rising edge; holding wr_en high does not repeat.
- Accepted in-range write: shadow[wr_addr] <= (shadow & ~wr_mask) | (wr_data & wr_mask); pending <= 1, even if the value is unchanged.
- Out-of-range write: shadow and pending unchanged; wr_err pulses.
- Commit with pending=1: active <= shadow; pending <= 0; applied pulses.
- Commit with pending=0: no-op; no applied pulse.
- Commit while high for several cycles: acts on each cycle; applied pulses only on cycles where pending was 1.
- Write edge and commit in the same cycle: the write is forwarded. Active receives the shadow with that write merged. pending ends at 0, and applied pulses. An out-of-range write in that cycle commits the existing shadow only.
- AUTO_COMMIT=1: every accepted in-range write behaves as if commit were high in the same cycle. pending stays 0. The commit input is still honoured.
- Readback: rd_data <= (rd_addr < NUM_REGS) ? shadow[rd_addr] : 0. Reads the shadow state before any write in the same cycle.
- Reset values: shadow = active = RESET_VALUES; rd_data = 0; pending = 0; applied = 0; wr_err = 0; wr_en_q = 1. Because wr_en_q resets to 1, a wr_en held high across reset release is not a write edge.
- Reset mid-operation: has priority over write and commit in the same cycle. All state returns to reset values, and uncommitted writes are lost.

## Timing
- Write: edge sampled at posedge N; shadow updated at N; rd_data reflects it for a read sampled at N+1 or later.
- Commit: sampled at posedge N; active, pending and applied are valid after N. applied is high for exactly cycle N..N+1.
- wr_err is high for the cycle after the edge.
- Read latency is 1 cycle. Back-to-back reads give one result per cycle.
- Minimum write spacing: wr_en low for at least 1 cycle between writes (2 cycles per write).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset/defaults: NUM_REGS=8, DATA_WIDTH=8, RESET_VALUES reg3=0xA5, with wr_en high during and after reset -> no write accepted; active reg3=0xA5, others 0; pending=0; rd_addr=3 gives rd_data=0xA5 one cycle later.
- Masked write and commit: write reg2 data 0xFF mask 0x0F, then data 0x00 mask 0xF0 -> rd_data=0x0F, pending=1, active reg2 still 0. Pulse commit -> active reg2=0x0F, applied single pulse, pending=0.
- Held strobe: wr_en high for 5 cycles with data 0x11 then 0x22 on reg1 -> only 0x11 written. Drop wr_en, raise it again with 0x22 -> 0x22 written.
- Simultaneous write and commit: pending=0, write reg4=0x5A in the same cycle as commit -> active reg4=0x5A next cycle, pending=0, applied=1. A second commit -> applied stays 0.
- Out-of-range: NUM_REGS=5, write addr 6 -> wr_err pulses one cycle, shadow unchanged, pending unchanged. Read addr 7 -> rd_data=0.
- AUTO_COMMIT=1: write reg0=0x3C -> active reg0=0x3C one cycle after the edge, applied pulses, pending never 1. Reset asserted in the cycle after a write -> active returns to RESET_VALUES.
